// File: rtl/monster_hp_bank.sv
// monster_hp_bank: hit-point store for NUM_MON monsters. Each monster has an
// ALIVE / INVULN / DEAD state machine with a post-hit invulnerability window,
// saturating damage, clamped healing, per-monster defeat pulses and an
// encounter-cleared level. Every output is driven from a flop.
module monster_hp_bank #(
  parameter int NUM_MON    = 4,
  parameter int HP_W       = 10,
  parameter int MAX_HP     = 511,
  parameter int HIT_CYCLES = 8,
  localparam int IDX_W     = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hit_valid,
  input  logic [IDX_W-1:0]        hit_idx,
  input  logic [HP_W-1:0]         hit_damage,
  input  logic                    heal_valid,
  input  logic [IDX_W-1:0]        heal_idx,
  input  logic [HP_W-1:0]         heal_amount,
  input  logic                    revive,
  output logic [NUM_MON*HP_W-1:0] hp_flat,
  output logic [NUM_MON-1:0]      alive,
  output logic [NUM_MON-1:0]      hit_flash,
  output logic                    hit_ack,
  output logic                    hit_ignored,
  output logic [NUM_MON-1:0]      defeated_pulse,
  output logic                    all_defeated
);

  localparam int CNT_W = $clog2(HIT_CYCLES + 1);
  localparam logic [HP_W-1:0]  MAX_HP_V = HP_W'(MAX_HP);
  localparam logic [HP_W:0]    MAX_HP_X = (HP_W + 1)'(MAX_HP);
  localparam logic [CNT_W-1:0] HIT_LOAD = CNT_W'(HIT_CYCLES);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } mon_state_e;

  mon_state_e       state_r    [NUM_MON];
  logic [CNT_W-1:0] cnt_r      [NUM_MON];
  logic [HP_W-1:0]  hp_r       [NUM_MON];

  mon_state_e       state_nx_s [NUM_MON];
  logic [CNT_W-1:0] cnt_nx_s   [NUM_MON];
  logic [HP_W-1:0]  hp_nx_s    [NUM_MON];
  logic [HP_W:0]    heal_sum_s [NUM_MON];
  logic [NUM_MON-1:0] kill_s;
  logic [NUM_MON-1:0] hit_sel_s;
  logic [NUM_MON-1:0] heal_sel_s;
  logic             hit_acc_s;
  logic             all_dead_s;

  // Per-monster next state: revive overrides everything, otherwise countdown,
  // then an accepted hit, else a heal (a heal loses to an accepted hit on the same target).
  always_comb begin
    hit_acc_s  = 1'b0;
    kill_s     = '0;
    hit_sel_s  = '0;
    heal_sel_s = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      state_nx_s[i] = state_r[i];
      cnt_nx_s[i]   = cnt_r[i];
      hp_nx_s[i]    = hp_r[i];
      heal_sum_s[i] = {1'b0, hp_r[i]} + {1'b0, heal_amount};
      if (revive) begin
        state_nx_s[i] = ST_ALIVE;
        cnt_nx_s[i]   = '0;
        hp_nx_s[i]    = MAX_HP_V;
      end else begin
        // Out-of-range indices never match any channel, so they fall through as rejected.
        hit_sel_s[i]  = hit_valid  && (hit_idx  == IDX_W'(i));
        heal_sel_s[i] = heal_valid && (heal_idx == IDX_W'(i));
        case (state_r[i])
          ST_ALIVE: begin
            state_nx_s[i] = ST_ALIVE;
          end
          ST_INVULN: begin
            if (cnt_r[i] <= CNT_W'(1)) begin
              state_nx_s[i] = ST_ALIVE;
              cnt_nx_s[i]   = '0;
            end else begin
              cnt_nx_s[i]   = cnt_r[i] - CNT_W'(1);
            end
          end
          ST_DEAD: begin
            state_nx_s[i] = ST_DEAD;
          end
          default: begin
            state_nx_s[i] = ST_ALIVE;
            cnt_nx_s[i]   = '0;
          end
        endcase
        if (hit_sel_s[i] && (state_r[i] == ST_ALIVE)) begin
          hit_acc_s = 1'b1;
          if (hit_damage >= hp_r[i]) begin
            hp_nx_s[i]    = '0;
            state_nx_s[i] = ST_DEAD;
            cnt_nx_s[i]   = '0;
            kill_s[i]     = 1'b1;
          end else if (hit_damage != '0) begin
            hp_nx_s[i]    = hp_r[i] - hit_damage;
            state_nx_s[i] = ST_INVULN;
            cnt_nx_s[i]   = HIT_LOAD;
          end else begin
            hp_nx_s[i]    = hp_r[i];
          end
        end else if (heal_sel_s[i] && (state_r[i] != ST_DEAD)) begin
          if (heal_sum_s[i] > MAX_HP_X) begin
            hp_nx_s[i] = MAX_HP_V;
          end else begin
            hp_nx_s[i] = heal_sum_s[i][HP_W-1:0];
          end
        end else begin
          hp_nx_s[i] = hp_nx_s[i];
        end
      end
    end
  end

  // Encounter is cleared when no monster will be out of DEAD next cycle.
  always_comb begin
    all_dead_s = 1'b1;
    for (int i = 0; i < NUM_MON; i++) begin
      if (state_nx_s[i] != ST_DEAD) begin
        all_dead_s = 1'b0;
      end else begin
        all_dead_s = all_dead_s;
      end
    end
  end

  // State, counters, HP and all status/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MON; i++) begin
        state_r[i] <= ST_ALIVE;
        cnt_r[i]   <= '0;
        hp_r[i]    <= MAX_HP_V;
      end
      alive          <= '1;
      hit_flash      <= '0;
      defeated_pulse <= '0;
      hit_ack        <= 1'b0;
      hit_ignored    <= 1'b0;
      all_defeated   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MON; i++) begin
        state_r[i]        <= state_nx_s[i];
        cnt_r[i]          <= cnt_nx_s[i];
        hp_r[i]           <= hp_nx_s[i];
        alive[i]          <= (state_nx_s[i] != ST_DEAD);
        hit_flash[i]      <= (state_nx_s[i] == ST_INVULN);
        defeated_pulse[i] <= kill_s[i];
      end
      hit_ack      <= hit_acc_s;
      hit_ignored  <= hit_valid && !revive && !hit_acc_s;
      all_defeated <= all_dead_s;
    end
  end

  // Flatten the HP flops onto the renderer bus.
  always_comb begin
    hp_flat = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      hp_flat[i*HP_W +: HP_W] = hp_r[i];
    end
  end

endmodule

// File: tb/tb_monster_hp_bank.sv
// tb_monster_hp_bank: directed vector table, randomized run against an
// abstract reference model, async reset mid-window, and a 3-monster instance
// for out-of-range indices.
module tb_monster_hp_bank;
  localparam int N = 4;
  localparam int W = 10;
  localparam int MAXHP = 511;
  localparam int HC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic hit_valid, heal_valid, revive;
  logic [1:0] hit_idx, heal_idx;
  logic [W-1:0] hit_damage, heal_amount;
  logic [N*W-1:0] hp_flat;
  logic [N-1:0] alive, hit_flash, defeated_pulse;
  logic hit_ack, hit_ignored, all_defeated;

  logic t_hit_valid, t_heal_valid, t_revive;
  logic [1:0] t_hit_idx, t_heal_idx;
  logic [W-1:0] t_hit_damage, t_heal_amount;
  logic [3*W-1:0] t_hp_flat;
  logic [2:0] t_alive, t_hit_flash, t_defeated_pulse;
  logic t_hit_ack, t_hit_ignored, t_all_defeated;

  monster_hp_bank #(.NUM_MON(N), .HP_W(W), .MAX_HP(MAXHP), .HIT_CYCLES(HC)) dut (
    .clk(clk), .rst_n(rst_n), .hit_valid(hit_valid), .hit_idx(hit_idx),
    .hit_damage(hit_damage), .heal_valid(heal_valid), .heal_idx(heal_idx),
    .heal_amount(heal_amount), .revive(revive), .hp_flat(hp_flat),
    .alive(alive), .hit_flash(hit_flash), .hit_ack(hit_ack),
    .hit_ignored(hit_ignored), .defeated_pulse(defeated_pulse),
    .all_defeated(all_defeated));

  monster_hp_bank #(.NUM_MON(3), .HP_W(W), .MAX_HP(MAXHP), .HIT_CYCLES(HC)) dut3 (
    .clk(clk), .rst_n(rst_n), .hit_valid(t_hit_valid), .hit_idx(t_hit_idx),
    .hit_damage(t_hit_damage), .heal_valid(t_heal_valid), .heal_idx(t_heal_idx),
    .heal_amount(t_heal_amount), .revive(t_revive), .hp_flat(t_hp_flat),
    .alive(t_alive), .hit_flash(t_hit_flash), .hit_ack(t_hit_ack),
    .hit_ignored(t_hit_ignored), .defeated_pulse(t_defeated_pulse),
    .all_defeated(t_all_defeated));

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int d);
    logic [N*W-1:0] r;
    r = {d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
    return r;
  endfunction

  typedef struct {
    logic hv; logic [1:0] hidx; logic [W-1:0] dmg;
    logic lv; logic [1:0] lidx; logic [W-1:0] amt;
    logic rev; int gap;
    logic [N*W-1:0] e_hp; logic [N-1:0] e_alive, e_flash, e_dp;
    logic e_ack, e_ign, e_all;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int hv, hidx, dmg, lv, lidx, amt, rev, gap,
                              h0, h1, h2, h3, al, fl, dp, ack, ign, all);
    vec_t v;
    v.hv = hv[0]; v.hidx = hidx[1:0]; v.dmg = dmg[W-1:0];
    v.lv = lv[0]; v.lidx = lidx[1:0]; v.amt = amt[W-1:0];
    v.rev = rev[0]; v.gap = gap;
    v.e_hp = pk(h0, h1, h2, h3);
    v.e_alive = al[N-1:0]; v.e_flash = fl[N-1:0]; v.e_dp = dp[N-1:0];
    v.e_ack = ack[0]; v.e_ign = ign[0]; v.e_all = all[0];
    return v;
  endfunction

  task automatic drive(input logic hv, input logic [1:0] hidx, input logic [W-1:0] dmg,
                       input logic lv, input logic [1:0] lidx, input logic [W-1:0] amt,
                       input logic rev);
    hit_valid = hv; hit_idx = hidx; hit_damage = dmg;
    heal_valid = lv; heal_idx = lidx; heal_amount = amt; revive = rev;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 10'd0, 1'b0, 2'd0, 10'd0, 1'b0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: HP as integers, a dead flag, and the step number at which
  // each monster's invulnerability ends.
  int m_hp[N];
  bit m_dead[N];
  int m_fend[N];
  int m_step;
  logic [N*W-1:0] e_hp;
  logic [N-1:0] e_alive, e_flash, e_dp;
  logic e_ack, e_ign, e_all;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_hp[i] = MAXHP; m_dead[i] = 1'b0; m_fend[i] = 0;
    end
    m_step = 0;
  endtask

  task automatic model_step(input logic hv, input int hidx, input int dmg,
                            input logic lv, input int lidx, input int amt, input logic rev);
    bit was_dead[N];
    bit hit_ok;
    e_ack = 1'b0; e_ign = 1'b0; e_dp = '0;
    if (rev) begin
      for (int i = 0; i < N; i++) begin
        m_hp[i] = MAXHP; m_dead[i] = 1'b0; m_fend[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) was_dead[i] = m_dead[i];
      hit_ok = hv && (hidx < N) && !m_dead[hidx] && !(m_step < m_fend[hidx]);
      if (hit_ok) begin
        e_ack = 1'b1;
        if (dmg >= m_hp[hidx]) begin
          m_hp[hidx] = 0; m_dead[hidx] = 1'b1; e_dp[hidx] = 1'b1;
        end else if (dmg > 0) begin
          m_hp[hidx] = m_hp[hidx] - dmg;
          m_fend[hidx] = m_step + HC + 1;
        end
      end else if (hv) begin
        e_ign = 1'b1;
      end
      if (lv && (lidx < N) && !was_dead[lidx] && !(hit_ok && hidx == lidx))
        m_hp[lidx] = (m_hp[lidx] + amt > MAXHP) ? MAXHP : m_hp[lidx] + amt;
    end
    m_step++;
    e_all = 1'b1;
    for (int i = 0; i < N; i++) begin
      e_hp[i*W +: W] = W'(m_hp[i]);
      e_alive[i] = !m_dead[i];
      e_flash[i] = !m_dead[i] && (m_step < m_fend[i]);
      if (!m_dead[i]) e_all = 1'b0;
    end
  endtask

  task automatic check_all(input string tag, input logic [N*W-1:0] hp, input logic [N-1:0] al,
                           input logic [N-1:0] fl, input logic [N-1:0] dp,
                           input logic ack, input logic ign, input logic all);
    chk({tag, ".hp_flat"}, 64'(hp_flat), 64'(hp));
    chk({tag, ".alive"}, 64'(alive), 64'(al));
    chk({tag, ".hit_flash"}, 64'(hit_flash), 64'(fl));
    chk({tag, ".defeated_pulse"}, 64'(defeated_pulse), 64'(dp));
    chk({tag, ".hit_ack"}, 64'(hit_ack), 64'(ack));
    chk({tag, ".hit_ignored"}, 64'(hit_ignored), 64'(ign));
    chk({tag, ".all_defeated"}, 64'(all_defeated), 64'(all));
  endtask

  initial begin
    logic r_hv, r_lv, r_rev;
    logic [1:0] r_hidx, r_lidx;
    logic [W-1:0] r_dmg, r_amt;
    int sel;

    idle();
    t_hit_valid = 1'b0; t_hit_idx = 2'd0; t_hit_damage = 10'd0;
    t_heal_valid = 1'b0; t_heal_idx = 2'd0; t_heal_amount = 10'd0; t_revive = 1'b0;

    // Reset state
    #12;
    check_all("reset", pk(511, 511, 511, 511), 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("reset3.hp_flat", 64'(t_hp_flat), 64'({10'd511, 10'd511, 10'd511}));
    rst_n = 1'b1;

    //          hv hi dmg  lv li amt rev gap  h0   h1   h2   h3   al   fl   dp  ack ign all
    tbl.push_back(mk(0, 0,   0, 0, 0,  0, 0, 0, 511, 511, 511, 511, 'hF, 'h0, 'h0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 100, 0, 0,  0, 0, 0, 511, 411, 511, 511, 'hF, 'h2, 'h0, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0,  0, 0, 0, 511, 411, 511, 511, 'hF, 'h2, 'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0,  0, 0, 0, 511, 411, 511, 511, 'hF, 'h2, 'h0, 0, 0, 0));
    tbl.push_back(mk(1, 1,  50, 0, 0,  0, 0, 0, 511, 411, 511, 511, 'hF, 'h2, 'h0, 0, 1, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0,  0, 0, 0, 511, 411, 511, 511, 'hF, 'h2, 'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0,  0, 0, 0, 511, 411, 511, 511, 'hF, 'h2, 'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0,  0, 0, 0, 511, 411, 511, 511, 'hF, 'h2, 'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0,  0, 0, 0, 511, 411, 511, 511, 'hF, 'h2, 'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0,  0, 0, 0, 511, 411, 511, 511, 'hF, 'h0, 'h0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 600, 0, 0,  0, 0, 0, 511, 411,   0, 511, 'hB, 'h0, 'h4, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 1, 2, 50, 0, 0, 511, 411,   0, 511, 'hB, 'h0, 'h0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 100, 0, 0,  0, 0, 0, 411, 411,   0, 511, 'hB, 'h1, 'h0, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 1, 0,200, 0, 0, 511, 411,   0, 511, 'hB, 'h1, 'h0, 0, 0, 0));
    tbl.push_back(mk(1, 0,  10, 1, 0, 50, 0, 7, 501, 411,   0, 511, 'hB, 'h1, 'h0, 1, 0, 0));
    tbl.push_back(mk(1, 0,1023, 0, 0,  0, 0, 8,   0, 411,   0, 511, 'hA, 'h0, 'h1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 411, 0, 0,  0, 0, 0,   0,   0,   0, 511, 'h8, 'h0, 'h2, 1, 0, 0));
    tbl.push_back(mk(1, 2,   5, 0, 0,  0, 0, 0,   0,   0,   0, 511, 'h8, 'h0, 'h0, 0, 1, 0));
    tbl.push_back(mk(1, 3, 511, 0, 0,  0, 0, 0,   0,   0,   0,   0, 'h0, 'h0, 'h8, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0, 0,  0, 0, 0,   0,   0,   0,   0, 'h0, 'h0, 'h0, 0, 0, 1));
    tbl.push_back(mk(1, 0,   5, 1, 1,  3, 1, 0, 511, 511, 511, 511, 'hF, 'h0, 'h0, 0, 0, 0));
    tbl.push_back(mk(1, 3,   0, 0, 0,  0, 0, 0, 511, 511, 511, 511, 'hF, 'h0, 'h0, 1, 0, 0));

    foreach (tbl[k]) begin
      for (int g = 0; g < tbl[k].gap; g++) begin
        idle();
        cycle();
      end
      drive(tbl[k].hv, tbl[k].hidx, tbl[k].dmg, tbl[k].lv, tbl[k].lidx, tbl[k].amt, tbl[k].rev);
      cycle();
      idle();
      check_all($sformatf("vec%0d", k), tbl[k].e_hp, tbl[k].e_alive, tbl[k].e_flash,
                tbl[k].e_dp, tbl[k].e_ack, tbl[k].e_ign, tbl[k].e_all);
    end

    // Randomized run against the reference model
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    model_reset();
    for (int it = 0; it < 1500; it++) begin
      r_hv = ($urandom_range(0, 99) < 60);
      r_hidx = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      if (sel == 0) r_dmg = 10'd0;
      else if (sel == 1) r_dmg = 10'($urandom_range(400, 1023));
      else r_dmg = 10'($urandom_range(1, 150));
      r_lv = ($urandom_range(0, 99) < 40);
      r_lidx = 2'($urandom_range(0, 3));
      r_amt = 10'($urandom_range(0, 300));
      r_rev = ($urandom_range(0, 99) < 2);
      drive(r_hv, r_hidx, r_dmg, r_lv, r_lidx, r_amt, r_rev);
      model_step(r_hv, int'(r_hidx), int'(r_dmg), r_lv, int'(r_lidx), int'(r_amt), r_rev);
      cycle();
      check_all("rand", e_hp, e_alive, e_flash, e_dp, e_ack, e_ign, e_all);
    end
    idle();

    // Async reset in the middle of an invulnerability window
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive(1'b1, 2'd2, 10'd7, 1'b0, 2'd0, 10'd0, 1'b0);
    cycle();
    idle();
    chk("midrst.flash_before", 64'(hit_flash), 64'(4'h4));
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.hit_flash", 64'(hit_flash), 64'(4'h0));
    chk("midrst.hp_flat", 64'(hp_flat), 64'(pk(511, 511, 511, 511)));
    chk("midrst.alive", 64'(alive), 64'(4'hF));
    cycle();
    rst_n = 1'b1;

    // Three-monster instance: index 3 is out of range
    t_hit_valid = 1'b1; t_hit_idx = 2'd3; t_hit_damage = 10'd100;
    cycle();
    t_hit_valid = 1'b0;
    chk("n3.idx3_ignored", 64'(t_hit_ignored), 64'(1'b1));
    chk("n3.idx3_ack", 64'(t_hit_ack), 64'(1'b0));
    chk("n3.idx3_hp", 64'(t_hp_flat), 64'({10'd511, 10'd511, 10'd511}));
    t_hit_valid = 1'b1; t_hit_idx = 2'd2; t_hit_damage = 10'd100;
    cycle();
    t_hit_valid = 1'b0;
    chk("n3.idx2_ack", 64'(t_hit_ack), 64'(1'b1));
    chk("n3.idx2_hp", 64'(t_hp_flat), 64'({10'd411, 10'd511, 10'd511}));
    chk("n3.idx2_flash", 64'(t_hit_flash), 64'(3'b100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/monster_hp_bank.md
Name: monster_hp_bank

Overview:
Parametrised successor to the single-monster HP register. It holds hit points for NUM_MON monsters, each with its own state machine (ALIVE / INVULN / DEAD) and a post-hit invulnerability window. It applies saturating damage and clamped healing, and reports per-monster defeat events plus an encounter-cleared flag. It sits between the attack/damage logic and the battle-screen renderer and scene controller.

Parameters:
NUM_MON, 4, number of monster channels (1..16)
HP_W, 10, HP, damage and heal width in bits
MAX_HP, 511, reset/revive HP value and heal ceiling (must be < 2**HP_W)
HIT_CYCLES, 8, invulnerability window length in clk cycles after a non-lethal hit (>=1)
IDX_W, clog2(NUM_MON) (minimum 1), index width; derived, not overridden

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
hit_valid  in  1  one-cycle damage request
hit_idx  in  IDX_W  target monster of the damage request
hit_damage  in  HP_W  damage amount
heal_valid  in  1  one-cycle heal request
heal_idx  in  IDX_W  target monster of the heal request
heal_amount  in  HP_W  heal amount
revive  in  1  restore all monsters
hp_flat  out  NUM_MON*HP_W  HP of monster i at bits [i*HP_W +: HP_W]
alive  out  NUM_MON  1 when the monster is not DEAD
hit_flash  out  NUM_MON  1 while the monster is in INVULN
hit_ack  out  1  one-cycle pulse: hit accepted
hit_ignored  out  1  one-cycle pulse: hit rejected
defeated_pulse  out  NUM_MON  one-cycle pulse when HP reaches 0
all_defeated  out  1  level: every monster is DEAD

Behaviour:
- All outputs are registered. Every request gets its response on the cycle after it is sampled.
- Reset (async on rst_n low), and the post-reset state:
  - every hp = MAX_HP, every state = ALIVE, invulnerability counters = 0
  - all pulses = 0, all_defeated = 0, alive = all ones
- Per-monster FSM:
  - ALIVE -> INVULN: accepted hit with damage > 0 that leaves HP > 0. Counter loads HIT_CYCLES.
  - ALIVE -> DEAD: accepted hit with damage >= hp.
  - INVULN: counter decrements every cycle. When it reaches 0 the state returns to ALIVE, so hit_flash is high for exactly HIT_CYCLES cycles.
  - DEAD: absorbing. Only revive or reset leaves it.
- Hit acceptance:
  - A hit is accepted only if hit_idx < NUM_MON and the target is ALIVE.
  - A hit on an INVULN or DEAD target, or with an out-of-range index, is rejected. It gets a hit_ignored pulse and no state change.
- Damage arithmetic: saturating. hp_next = (hit_damage >= hp) ? 0 : hp - hit_damage.
- Zero damage: accepted with hit_ack, HP unchanged, no INVULN entry.
- Heal:
  - Applies only to a non-DEAD monster with heal_idx < NUM_MON, in either ALIVE or INVULN.
  - Sum is computed at HP_W+1 bits and clamped: hp_next = min(hp + heal_amount, MAX_HP).
  - A heal does not alter the state or the counter. A heal on a DEAD monster is silently dropped.
- Simultaneous hit and heal:
  - Different targets: both are applied in the same cycle.
  - Same target with the hit accepted: the hit is applied and the heal is dropped.
  - Same target with the hit rejected: the heal is applied normally.
- defeated_pulse[i]: high for one cycle, in the cycle hp_i first reads 0.
- all_defeated: asserts in the same cycle as the last defeated_pulse. It stays high until revive or reset.
- revive (highest priority):
  - Next cycle, every hp = MAX_HP, every state = ALIVE and counters are cleared.
  - Hit and heal requests in that cycle are discarded with no ack and no ignored pulse.
  - No defeated_pulse is produced, and all_defeated falls.
- Reset asserted mid-window immediately restores the reset state, regardless of INVULN counters or pending pulses.

Test Plan:
- Reset, NUM_MON=4 -> every hp=511, alive=4'b1111, hit_flash=0, all_defeated=0.
- Hit idx 1, damage 100 -> next cycle hp1=411, hit_ack=1, hit_flash[1]=1 for exactly 8 cycles. A second hit on idx 1 at cycle+3 -> hit_ignored=1, hp1 stays 411.
- Hit idx 2, damage 600 (exceeds hp=511) -> hp2=0, alive[2]=0, defeated_pulse[2] for 1 cycle. A later heal of 50 on idx 2 -> hp2 stays 0.
- hp0=411, heal 200 -> hp0=511 (clamped). Same cycle, hit idx 0 damage 10 plus heal idx 0 amount 50 from ALIVE -> hp0=501 and the heal is dropped.
- Kill monsters 0..3 in sequence -> all_defeated rises in the same cycle as defeated_pulse[3]. revive -> next cycle all hp=511, alive=1111, all_defeated=0.
- hit_idx=3 with NUM_MON=3 -> hit_ignored=1, no hp change. Assert rst_n low during an INVULN window -> hit_flash=0 and hp=MAX_HP immediately.
